// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// Shared constants for the nibble-serial adder sequencer: state encoding,
// nibble width and the nibble-index width helper.
package nibble_serial_adder_ctrl_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int NIBBLE_W = 4;

  // clog2 of the nibble count, never narrower than one bit.
  function automatic int idx_width(input int nibbles);
    return (nibbles <= 2) ? 1 : $clog2(nibbles);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_ctrl_full_adder.sv
// 4-bit ripple full adder: {Cout, S} = A + B + Cin.
module nibble_serial_adder_ctrl_full_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       Cin,
  output logic [3:0] S,
  output logic       Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// Wide add/subtract sequencer: one shared 4-bit adder is stepped across the
// operands one nibble per clock, LSB nibble first, carry held between nibbles.
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      op_sub,
  input  logic [4*NIBBLES-1:0]      a,
  input  logic [4*NIBBLES-1:0]      b,
  output logic                      busy,
  output logic                      done,
  output logic [4*NIBBLES-1:0]      sum,
  output logic                      cout,
  output logic                      overflow
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  logic               state;
  logic               state_nx;
  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic               carry;
  logic [IDX_W-1:0]   idx;
  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] add_s;
  logic               add_co;
  logic               last;

  assign nib_a = op_a[idx*NIBBLE_W +: NIBBLE_W];
  assign nib_b = op_b[idx*NIBBLE_W +: NIBBLE_W];
  assign last  = (idx == IDX_W'(NIBBLES - 1));

  nibble_serial_adder_ctrl_full_adder u_adder (
    .A   (nib_a),
    .B   (nib_b),
    .Cin (carry),
    .S   (add_s),
    .Cout(add_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = ST_RUN;
      ST_RUN:  if (last)  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_RUN);
  end

  // Subtraction is A + ~B + 1: B is inverted at capture and the carry seeded with 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_a  <= a;
            op_b  <= op_sub ? ~b : b;
            carry <= op_sub;
            idx   <= '0;
          end
        end
        default: begin
          sum[idx*NIBBLE_W +: NIBBLE_W] <= add_s;
          carry <= add_co;
          idx   <= idx + 1'b1;
          if (last) begin
            cout     <= add_co;
            overflow <= (op_a[W-1] == op_b[W-1]) && (add_s[NIBBLE_W-1] != op_a[W-1]);
            done     <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for the nibble-serial adder sequencer with NIBBLES=4.
module tb_nibble_serial_adder_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op_sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op_sub  (op_sub),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .sum     (sum),
    .cout    (cout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done (bounded); returns number of edges waited.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                        input logic vsub, input logic [15:0] es, input logic ec, input logic eo);
    int n;
    start = 1'b1; a = va; b = vb; op_sub = vsub;
    tick();
    start = 1'b0; a = '0; b = '0; op_sub = 1'b0;
    chk({tag, "_busy"}, busy, 1);
    wait_done(n);
    chk({tag, "_lat"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, overflow, eo);
    chk({tag, "_idle"}, busy, 0);
    tick();
    chk({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int n;
    int dc;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Start during RUN is ignored.
    dc = done_cnt;
    start = 1'b1; a = 16'h0011; b = 16'h0022; op_sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; op_sub = 1'b1;
    tick();
    start = 1'b0; a = '0; b = '0; op_sub = 1'b0;
    wait_done(n);
    chk("ign_lat", n, 2);
    chk("ign_sum", sum, 16'h0033);
    chk("ign_cout", cout, 0);
    repeat (6) tick();
    chk("ign_one_done", done_cnt - dc, 1);
    chk("ign_idle", busy, 0);

    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Asynchronous reset after two RUN edges.
    start = 1'b1; a = 16'h1111; b = 16'h2222; op_sub = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("mid_partial", sum, 16'h7F33);
    chk("mid_cout_hold", cout, 1);
    chk("mid_ovf_hold", overflow, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sum", sum, 0);
    chk("arst_cout", cout, 0);
    chk("arst_ovf", overflow, 0);
    #3 rst = 1'b0;
    dc = done_cnt;
    repeat (6) tick();
    chk("arst_no_done", done_cnt - dc, 0);
    chk("arst_idle", busy, 0);
    run_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 16'h1010, 1'b0, 1'b0);

    // Back-to-back with start held high.
    start = 1'b1; a = 16'h0001; b = 16'h0002; op_sub = 1'b0;
    tick();
    a = 16'h1000; b = 16'h0001; op_sub = 1'b1;
    wait_done(n);
    chk("b2b1_lat", n, 4);
    chk("b2b1_sum", sum, 16'h0003);
    chk("b2b1_cout", cout, 0);
    tick();
    chk("b2b_accept_done", done, 0);
    chk("b2b_accept_busy", busy, 1);
    a = 16'hFFFF; b = 16'hFFFF; op_sub = 1'b0;
    wait_done(n);
    chk("b2b2_lat", n, 4);
    chk("b2b2_sum", sum, 16'h0FFF);
    chk("b2b2_cout", cout, 1);
    chk("b2b2_ovf", overflow, 0);
    tick();
    start = 1'b0;
    chk("b2b3_busy", busy, 1);
    wait_done(n);
    chk("b2b3_lat", n, 4);
    chk("b2b3_sum", sum, 16'hFFFE);
    chk("b2b3_cout", cout, 1);
    chk("b2b3_ovf", overflow, 0);
    tick();
    chk("b2b3_end", done, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that performs a wide add or subtract (4*NIBBLES bits) by time-multiplexing one 4-bit FullAdder, one nibble per clock, LSB nibble first.
- Holds the carry between nibbles in a register.
- Exposes a start/busy/done handshake to the host logic.
- Sits between the host and the 4-bit adder datapath; the result is held stable until the next accepted start.

Parameters:
- NIBBLES, 4, operand width in nibbles; total width W = 4*NIBBLES; legal range 1..16.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- op_sub  in  1  0 = A+B, 1 = A-B; sampled with start.
- a  in  W  operand A; sampled with start.
- b  in  W  operand B; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when the result is valid.
- sum  out  W  result register.
- cout  out  1  final carry out. For sub, 1 = no borrow.
- overflow  out  1  signed two's-complement overflow of the W-bit result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, overflow=0. Internal carry register, nibble index and operand registers are also cleared.
- States: IDLE and RUN.
- IDLE, on an edge E0 with start=1:
  - latch a into opA.
  - latch b, or ~b when op_sub=1, into opB.
  - carry <= op_sub; idx <= 0; busy <= 1; done <= 0.
  - go to RUN.
- IDLE with start=0: hold all outputs. done is cleared on that edge.
- RUN, on each edge Ek (k = 1..NIBBLES):
  - adder inputs are opA[idx], opB[idx] and carry.
  - sum[idx] <= S; carry <= Cout; idx <= idx+1.
  - other sum nibbles are untouched.
- On the edge that writes nibble NIBBLES-1:
  - cout <= adder Cout.
  - overflow <= (opA msb == opB msb) && (S msb != opA msb).
  - busy <= 0; done <= 1; go to IDLE.
- Latency: done is high in the cycle following edge E_NIBBLES, i.e. NIBBLES cycles after start is sampled. Throughput is one operation per NIBBLES+1 cycles at best.
- start while busy=1 is ignored. It is not queued, and a, b, op_sub changes have no effect.
- Back-to-back: start=1 during the done cycle is accepted on that edge. done drops and busy rises on the same edge.
- sum is partially updated during RUN. Consumers read it only when done=1, or in IDLE after done.
- cout and overflow update only on the final nibble edge. They hold their previous values during RUN.
- rst asserted mid-RUN forces the reset values immediately. No done pulse is produced for the aborted operation.
- NIBBLES=1: RUN lasts exactly one edge, which is also the final-nibble edge.

Decomposition:
- Shared package holds:
  - localparams ST_IDLE and ST_RUN, 1-bit encoding.
  - NIBBLE_W = 4.
  - an index-width function, clog2 of NIBBLES, minimum 1.
- Sub-module: one instance of the existing 4-bit FullAdder (A, B, Cin -> S, Cout), instance name u_adder.
- Operand nibble selection and the sum write are done in this module. No other sub-modules.

Test Plan:
- NIBBLES=4, rst pulse, then start with a=16'h1234, b=16'h4321, op_sub=0 -> busy high for 4 cycles; done pulses one cycle 4 cycles after start; sum=16'h5555, cout=0, overflow=0.
- a=16'hFFFF, b=16'h0001, add -> sum=16'h0000, cout=1, overflow=0. Then a=16'h7FFF, b=16'h0001, add -> sum=16'h8000, cout=0, overflow=1.
- op_sub=1 with a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0 (borrow), overflow=0. Then a=16'h8000, b=16'h0001 -> sum=16'h7FFF, cout=1, overflow=1.
- Start a=16'h0011, b=16'h0022, add. During RUN pulse start with a=16'hAAAA, b=16'h5555 -> the second start is ignored; sum=16'h0033; exactly one done pulse.
- Start an add, then assert rst asynchronously (mid-clock) after 2 RUN edges -> busy, done, sum, cout and overflow go to 0 immediately; no done pulse after rst releases; the next start computes correctly.
- Hold start=1 continuously with alternating operands -> done pulses every 5 cycles; each result matches the operands sampled at the corresponding accepting edge.
